dp_ram_fifo_ctrl: RTL and testbench
===================================

Name: dp_ram_fifo_ctrl

Overview:
Synchronous FIFO controller placed in front of the team's dual-port RAM. It accepts a valid/ready write stream, stores entries in the external RAM, and prefetches them into a 2-entry output buffer so the consumer sees a show-ahead valid/ready stream. The RAM has single-cycle read latency and drops a read issued in the same cycle as a write, so this block arbitrates so that at most one RAM access happens per cycle.

Parameters:
WIDTH, 8, data width in bits (matches RAM WIDTH)
DEPTH, 1024, RAM entries; any value >= 2, power of two not required
AW, $clog2(DEPTH), localparam, RAM address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active high
s_valid  in  1  write-side data valid
s_ready  out  1  write-side ready
s_data  in  WIDTH  write-side data
m_valid  out  1  read-side data valid
m_ready  in  1  read-side ready
m_data  out  WIDTH  read-side data, head of FIFO
count  out  AW+2  total occupancy, RAM plus in-flight plus output buffer, 0..DEPTH+2
ram_wr  out  1  RAM write enable
ram_waddr  out  AW  RAM write address
ram_din  out  WIDTH  RAM write data, equals s_data
ram_rd  out  1  RAM read enable
ram_raddr  out  AW  RAM read address
ram_dout  in  WIDTH  RAM read data, valid the cycle after ram_rd

Behaviour:
- Reset (rst_n=0, async): wptr=rptr=0, ram_cnt=0, inflight=0, ob_cnt=0, last_rd=0. Outputs go to m_valid=0, count=0, ram_wr=0, ram_rd=0, m_data=0. s_ready=1 from the first cycle after release. RAM contents are not cleared. Reset mid-operation discards all data and any in-flight read.
- Read request: rd_want = (ram_cnt>0) && (ob_cnt+inflight<2). Computed from registered state only.
- Read grant: rd_grant = rd_want && (ob_cnt+inflight==0 || !last_rd). ram_rd = rd_grant. last_rd <= rd_grant every cycle.
- s_ready = (ram_cnt<DEPTH) && !rd_grant && !clr. There is no combinational path from s_valid or m_ready to s_ready.
- ram_wr = s_valid && s_ready. ram_waddr = wptr. ram_rd and ram_wr are never both 1.
- Pointers wrap explicitly from DEPTH-1 to 0.
- ram_cnt changes by +1 on a write and -1 on a read grant. The two never occur in the same cycle.
- inflight <= rd_grant. When inflight=1, ram_dout is captured into the output buffer at the end of that cycle.
- Output buffer: 2-entry FIFO of registers. m_valid = (ob_cnt>0), m_data = head entry. A pop (m_valid && m_ready) and a capture in the same cycle keep ob_cnt unchanged. The buffer never overflows, by construction of rd_want.
- Latency into an empty FIFO: s_data accepted in cycle 0 -> ram_rd in cycle 1 -> capture at the end of cycle 2 -> m_valid=1 in cycle 3.
- Throughput: with both sides continuously active, sustained rate is 1 entry per 2 cycles (reads and writes alternate). Full rate applies to writes alone into non-full RAM, and to draining the output buffer.
- Full: ram_cnt==DEPTH -> s_ready=0. The buffer plus in-flight slot still hold up to 2 more entries, so count maximum is DEPTH+2.
- Empty: count==0 -> m_valid=0, ram_rd=0.
- clr=1: at the clock edge, pointers, ram_cnt, ob_cnt, inflight and last_rd are cleared. Any capture that cycle is discarded. ram_wr=0 that cycle because s_ready=0. m_valid=0 in the next cycle.
- count is registered and updated every cycle from the next-state values.

Decomposition:
- Shared package fifo_pkg: function clog2_safe (returns 1 for DEPTH<=2), localparam OB_DEPTH=2.
- One sub-module fits naturally: fifo_out_buf, the 2-entry register skid buffer with capture_en, capture_data, pop, ob_cnt and head outputs.
- The pointer, arbitration and count logic stays in dp_ram_fifo_ctrl.
- The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, then push 0xA5 in cycle 0 with m_ready=1 -> ram_wr in cycle 0 at waddr 0, ram_rd in cycle 1 at raddr 0, m_valid=1 with m_data=0xA5 in cycle 3, count returns to 0 after the pop.
- DEPTH=4, m_ready=0, push 0x01..0x07 -> first 6 accepted (4 in RAM, 2 in buffer), s_ready=0 after that, count=6. Then drain -> data 0x01..0x06 in order.
- DEPTH=5, 13 push/pop pairs -> wptr/rptr wrap 4->0. Output sequence matches input, no ram_wr && ram_rd in any cycle (assertion).
- Continuous s_valid and m_ready with a random RAM model -> ordering preserved, no overflow/underflow assertions fire, steady throughput >= 1 entry per 2 cycles.
- clr asserted while count=3 and a read is in flight -> next cycle m_valid=0, count=0. A subsequent push of 0x3C emerges first, with no stale data.
- rst_n deasserted asynchronously mid-burst (between clock edges) -> outputs go to reset values immediately. After release, the first push returns the correct data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
package fifo_pkg;

    localparam int unsigned OB_DEPTH = 2;
    localparam int unsigned OB_CW    = 2;

    // Address width that stays at least one bit for tiny RAMs.
    function automatic int unsigned clog2_safe(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry register buffer holding prefetched RAM data; entry 0 is the head.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             capture_en_i,
    input  logic [WIDTH-1:0] capture_data_i,
    input  logic             pop_i,
    output logic [OB_CW-1:0] ob_cnt_o,
    output logic [OB_CW-1:0] ob_cnt_nxt_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [OB_CW-1:0] cnt_q, cnt_d;

    // Pop shifts entry 1 forward; a capture lands in the first free slot.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else begin
            case ({pop_i, capture_en_i})
                2'b01: begin
                    if (cnt_q == '0) e0_d = capture_data_i;
                    else             e1_d = capture_data_i;
                    cnt_d = cnt_q + OB_CW'(1);
                end
                2'b10: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - OB_CW'(1);
                end
                2'b11: begin
                    if (cnt_q == OB_CW'(OB_DEPTH)) begin
                        e0_d = e1_q;
                        e1_d = capture_data_i;
                    end else begin
                        e0_d = capture_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign ob_cnt_o     = cnt_q;
    assign ob_cnt_nxt_o = cnt_d;
    assign head_o       = e0_q;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: one RAM access per cycle,
// with a two-entry prefetch buffer giving a show-ahead read stream.
module dp_ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [AW+1:0]    count,
    output logic             ram_wr,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_rd,
    output logic [AW-1:0]    ram_raddr,
    input  logic [WIDTH-1:0] ram_dout
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = AW + 2;

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    logic             inflight_q, inflight_d;
    logic             last_rd_q, last_rd_d;
    logic             run_q;
    logic [NW-1:0]    count_q, count_d;
    logic [OB_CW-1:0] ob_cnt, ob_cnt_nxt, occ;
    logic             rd_want, rd_grant, pop;

    // Reads and writes alternate whenever both want the RAM.
    assign occ      = ob_cnt + OB_CW'(inflight_q);
    assign rd_want  = (ram_cnt_q != '0) && (occ < OB_CW'(OB_DEPTH));
    assign rd_grant = rd_want && ((occ == '0) || !last_rd_q);
    assign s_ready  = run_q && (ram_cnt_q < CW'(DEPTH)) && !rd_grant && !clr;
    assign ram_wr   = s_valid && s_ready;
    assign ram_rd   = rd_grant;

    assign ram_waddr = wptr_q;
    assign ram_raddr = rptr_q;
    assign ram_din   = s_data;
    assign m_valid   = (ob_cnt != '0);
    assign pop       = m_valid && m_ready;
    assign count     = count_q;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = rd_grant;
        last_rd_d  = rd_grant;
        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            last_rd_d  = 1'b0;
        end else if (ram_wr) begin
            wptr_d    = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q + CW'(1);
        end else if (rd_grant) begin
            rptr_d    = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            ram_cnt_d = ram_cnt_q - CW'(1);
        end
        count_d = NW'(ram_cnt_d) + NW'(inflight_d) + NW'(ob_cnt_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            last_rd_q  <= 1'b0;
            run_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            last_rd_q  <= last_rd_d;
            run_q      <= 1'b1;
            count_q    <= count_d;
        end
    end

    fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (clr),
        .capture_en_i   (inflight_q),
        .capture_data_i (ram_dout),
        .pop_i          (pop),
        .ob_cnt_o       (ob_cnt),
        .ob_cnt_nxt_o   (ob_cnt_nxt),
        .head_o         (m_data)
    );

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl with a small non-power-of-two RAM and a queue-based model.
module tb_dp_ram_fifo_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned AW    = 3;

    logic             clk, rst_n, clr;
    logic             s_valid, s_ready, m_valid, m_ready;
    logic [WIDTH-1:0] s_data, m_data, ram_din, ram_dout;
    logic [AW+1:0]    count;
    logic             ram_wr, ram_rd;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] mem [DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    dp_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .ram_wr    (ram_wr),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_rd    (ram_rd),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle-latency RAM; a read colliding with a write is dropped.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_din;
        if (ram_rd && !ram_wr) ram_dout <= mem[ram_raddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of accepted-but-not-consumed data and modulo RAM pointers.
    initial begin : scoreboard
        logic [WIDTH-1:0] q[$];
        int wp_m, rp_m;
        wp_m = 0;
        rp_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                wp_m = 0;
                rp_m = 0;
            end else begin
                check_eq("count", 32'(count), 32'(q.size()));
                check_eq("no_wr_and_rd", 32'(ram_wr && ram_rd), 0);
                check_eq("ram_wr", 32'(ram_wr), 32'(s_valid && s_ready));
                if (q.size() == 0) begin
                    check_eq("m_valid_empty", 32'(m_valid), 0);
                    check_eq("ram_rd_empty", 32'(ram_rd), 0);
                    if (!clr) check_eq("s_ready_empty", 32'(s_ready), 1);
                end
                if (ram_wr) begin
                    check_eq("ram_waddr", 32'(ram_waddr), 32'(wp_m));
                    check_eq("ram_din", 32'(ram_din), 32'(s_data));
                    wp_m = (wp_m + 1) % DEPTH;
                end
                if (ram_rd) begin
                    check_eq("ram_raddr", 32'(ram_raddr), 32'(rp_m));
                    rp_m = (rp_m + 1) % DEPTH;
                end
                if (m_valid && m_ready && q.size() > 0) begin
                    check_eq("m_data_order", 32'(m_data), 32'(q[0]));
                    void'(q.pop_front());
                end
                if (ram_wr) q.push_back(s_data);
                if (clr) begin
                    q.delete();
                    wp_m = 0;
                    rp_m = 0;
                end
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] d, input int maxc, output bit ok);
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic pop(output logic [WIDTH-1:0] d, input int maxc, output bit ok);
        ok      = 1'b0;
        d       = '0;
        m_ready = 1'b1;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                d  = m_data;
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [WIDTH-1:0] d;
        bit ok;
        int acc, pops;

        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_ram_rd", 32'(ram_rd), 0);
        check_eq("rst_m_data", 32'(m_data), 0);
        #1 rst_n = 1'b1;
        next_cycle();

        // Latency into an empty FIFO: write c0, read c1, visible c3.
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        @(negedge clk);
        check_eq("lat_c0_wr", 32'(ram_wr), 1);
        check_eq("lat_c0_waddr", 32'(ram_waddr), 0);
        next_cycle(); s_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_c1_rd", 32'(ram_rd), 1);
        check_eq("lat_c1_raddr", 32'(ram_raddr), 0);
        check_eq("lat_c1_m_valid", 32'(m_valid), 0);
        @(negedge clk);
        check_eq("lat_c2_m_valid", 32'(m_valid), 0);
        @(negedge clk);
        check_eq("lat_c3_m_valid", 32'(m_valid), 1);
        check_eq("lat_c3_m_data", 32'(m_data), 32'h00A5);
        @(negedge clk);
        check_eq("lat_c4_count", 32'(count), 0);
        m_ready = 1'b0;
        repeat (3) next_cycle();

        // Fill: RAM plus buffer hold DEPTH+2 entries.
        acc = 0;
        for (int v = 1; v <= 8; v++) begin
            push(WIDTH'(v), 12, ok);
            if (ok) acc++;
        end
        @(negedge clk);
        check_eq("full_accepted", 32'(acc), DEPTH + 2);
        check_eq("full_count", 32'(count), DEPTH + 2);
        check_eq("full_s_ready", 32'(s_ready), 0);
        next_cycle();
        for (int i = 1; i <= 7; i++) begin
            pop(d, 12, ok);
            check_eq("drain_ok", 32'(ok), 1);
            check_eq("drain_data", 32'(d), 32'(i));
        end
        repeat (3) next_cycle();

        // Push/pop pairs walk both pointers across the DEPTH-1 -> 0 wrap.
        for (int i = 0; i < 13; i++) begin
            push(WIDTH'(8'h40 + i), 12, ok);
            check_eq("wrap_push_ok", 32'(ok), 1);
            pop(d, 12, ok);
            check_eq("wrap_pop_ok", 32'(ok), 1);
            check_eq("wrap_data", 32'(d), 32'(8'h40 + i));
        end
        repeat (3) next_cycle();

        // Build count=3 with a read in flight, then flush.
        for (int i = 0; i < 4; i++) begin
            push(WIDTH'(8'h11 + i), 12, ok);
            check_eq("clr_fill_ok", 32'(ok), 1);
        end
        m_ready = 1'b1;
        next_cycle(); m_ready = 1'b0;
        next_cycle(); clr = 1'b1;
        @(negedge clk);
        check_eq("clr_pre_count", 32'(count), 3);
        next_cycle(); clr = 1'b0;
        @(negedge clk);
        check_eq("clr_m_valid", 32'(m_valid), 0);
        check_eq("clr_count", 32'(count), 0);
        next_cycle();
        push(8'h3C, 12, ok);
        pop(d, 12, ok);
        check_eq("clr_after_ok", 32'(ok), 1);
        check_eq("clr_after_data", 32'(d), 32'h003C);
        repeat (3) next_cycle();

        // Both sides busy: at least one entry per two cycles.
        pops = 0;
        s_valid = 1'b1; m_ready = 1'b1; s_data = WIDTH'($urandom);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid) pops++;
            ok = s_ready;
            next_cycle();
            if (ok) s_data = WIDTH'($urandom);
        end
        s_valid = 1'b0;
        check_eq("throughput", 32'(pops >= 95), 1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 63) == 0);
            s_data  = WIDTH'($urandom);
            next_cycle();
        end
        s_valid = 1'b0; clr = 1'b0; m_ready = 1'b0;

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(8'h80 + i);
            next_cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_m_valid", 32'(m_valid), 0);
        check_eq("arst_count", 32'(count), 0);
        check_eq("arst_ram_wr", 32'(ram_wr), 0);
        check_eq("arst_ram_rd", 32'(ram_rd), 0);
        check_eq("arst_m_data", 32'(m_data), 0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
        push(8'h5A, 12, ok);
        check_eq("arst_push_ok", 32'(ok), 1);
        pop(d, 12, ok);
        check_eq("arst_pop_ok", 32'(ok), 1);
        check_eq("arst_data", 32'(d), 32'h005A);
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
